lenet_result_reader: RTL and testbench

- Reader at the far end of the SRAM_f write interface. fc_top writes the final FC2 class scores into SRAM_f.
- After fc2_done, this block reads SRAM_f back and computes a signed argmax over the class scores.
- It presents the winning class index and its score on a valid/ready handshake to the host/testbench side of the LeNet top.

---
 rtl/lenet_pkg.sv | 34 +++
 rtl/lenet_argmax_lane4.sv | 70 +++++++
 rtl/lenet_result_reader.sv | 157 +++++++++++++++
 tb/tb_lenet_result_reader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet result reader.
//   - FSM state encoding (IDLE/READ/LAST/HOLD)
//   - Class count, SRAM_f geometry and number of words to read (NWORD)
//   - Lane extraction: lane k of a word occupies bits [31-8k -: 8]
package lenet_pkg;

  localparam int CLASS_NUM  = 10;
  localparam int DATA_WIDTH = 8;
  localparam int LANES      = 4;   // scores per SRAM_f word
  localparam int ADDR_WIDTH = 2;
  localparam int CLASS_W    = 4;
  localparam int WORD_WIDTH = LANES * DATA_WIDTH;
  localparam int NWORD      = (CLASS_NUM + LANES - 1) / LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    HOLD = 2'd3
  } state_e;

  // MSB position of lane k; lane 0 sits in the top byte.
  function automatic int lane_msb(input int k);
    return WORD_WIDTH - 1 - DATA_WIDTH * k;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] get_lane(
    input logic [WORD_WIDTH-1:0] word,
    input int                    k
  );
    return word[lane_msb(k) -: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/lenet_argmax_lane4.sv
// Combinational 4-lane signed argmax update.
//   word     : one SRAM_f word holding four scores (lane 0 first)
//   base     : class index of lane 0
//   mask     : lane k participates only when mask[k] is set
//   cur_*    : running max / index going in
//   new_*    : running max / index after scanning this word
// With LENET_RESULT_TOP2_EN defined, the runner-up (max2/idx2/has2) is
// tracked as well: the displaced max drops to second place, otherwise a
// score strictly greater than the current second replaces it.
module lenet_argmax_lane4
  import lenet_pkg::*;
(
  input  logic        [WORD_WIDTH-1:0] word,
  input  logic        [CLASS_W-1:0]    base,
  input  logic        [LANES-1:0]      mask,
  input  logic signed [DATA_WIDTH-1:0] cur_max,
  input  logic        [CLASS_W-1:0]    cur_idx,
  output logic signed [DATA_WIDTH-1:0] new_max,
  output logic        [CLASS_W-1:0]    new_idx
`ifdef LENET_RESULT_TOP2_EN
  ,
  input  logic signed [DATA_WIDTH-1:0] cur_max2,
  input  logic        [CLASS_W-1:0]    cur_idx2,
  input  logic                         cur_has2,
  output logic signed [DATA_WIDTH-1:0] new_max2,
  output logic        [CLASS_W-1:0]    new_idx2,
  output logic                         new_has2
`endif
);

  logic signed [DATA_WIDTH-1:0] score;
  logic        [CLASS_W-1:0]    idx;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    new_max = cur_max;
    new_idx = cur_idx;
    score   = '0;
    idx     = '0;
`ifdef LENET_RESULT_TOP2_EN
    new_max2 = cur_max2;
    new_idx2 = cur_idx2;
    new_has2 = cur_has2;
`endif
    // Ascending lane order plus strict '>' keeps the lowest index on ties.
    for (int k = 0; k < LANES; k++) begin
      score = get_lane(word, k);
      idx   = base + CLASS_W'(k);
      if (mask[k]) begin
        if (score > new_max) begin
`ifdef LENET_RESULT_TOP2_EN
          new_max2 = new_max;
          new_idx2 = new_idx;
          new_has2 = 1'b1;
`endif
          new_max = score;
          new_idx = idx;
        end
`ifdef LENET_RESULT_TOP2_EN
        else if (!new_has2 || score > new_max2) begin
          new_max2 = score;
          new_idx2 = idx;
          new_has2 = 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/lenet_result_reader.sv
// Reads the FC2 class scores back from SRAM_f after fc2_done and presents
// the signed argmax on a valid/ready handshake.
//   clk, srstn      : clock, asynchronous active-low reset
//   fc2_done        : one-cycle start pulse, honoured only in IDLE
//   sram_raddr_f    : SRAM_f read address (0 when not reading)
//   sram_rdata_f    : SRAM_f read data, one cycle after the address
//   busy            : cycle after start until result_valid rises
//   result_valid/ready, result_class, result_score : result handshake
// Optional macro LENET_RESULT_TOP2_EN adds result_class2/result_score2
// (runner-up), sharing the main handshake.
module lenet_result_reader
  import lenet_pkg::*;
(
  input  logic                         clk,
  input  logic                         srstn,
  input  logic                         fc2_done,
  output logic        [ADDR_WIDTH-1:0] sram_raddr_f,
  input  logic        [WORD_WIDTH-1:0] sram_rdata_f,
  output logic                         busy,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic        [CLASS_W-1:0]    result_class,
  output logic signed [DATA_WIDTH-1:0] result_score
`ifdef LENET_RESULT_TOP2_EN
  ,
  output logic        [CLASS_W-1:0]    result_class2,
  output logic signed [DATA_WIDTH-1:0] result_score2
`endif
);

  state_e                       state;
  logic                         rd_valid;   // address issue delayed one cycle
  logic        [ADDR_WIDTH-1:0] rd_addr;    // address of the word now on sram_rdata_f
  logic signed [DATA_WIDTH-1:0] run_max;
  logic        [CLASS_W-1:0]    run_idx;

  logic                         first;
  logic        [CLASS_W-1:0]    base;
  logic        [LANES-1:0]      mask;
  logic signed [DATA_WIDTH-1:0] in_max, upd_max;
  logic        [CLASS_W-1:0]    in_idx, upd_idx;

`ifdef LENET_RESULT_TOP2_EN
  logic signed [DATA_WIDTH-1:0] run_max2, upd_max2;
  logic        [CLASS_W-1:0]    run_idx2, upd_idx2;
  logic                         run_has2, in_has2, upd_has2;
`endif

  // Word 0 seeds the running max with score 0, so lane 0 is then masked
  // out and never competes against itself.
  always_comb begin
    first  = (rd_addr == '0);
    base   = CLASS_W'(int'(rd_addr) * LANES);
    in_max = first ? get_lane(sram_rdata_f, 0) : run_max;
    in_idx = first ? '0 : run_idx;
    mask   = '0;
    for (int k = 0; k < LANES; k++) begin
      mask[k] = (int'(base) + k < CLASS_NUM) && !(first && k == 0);
    end
`ifdef LENET_RESULT_TOP2_EN
    in_has2 = first ? 1'b0 : run_has2;
`endif
  end

  lenet_argmax_lane4 u_argmax (
    .word     (sram_rdata_f),
    .base     (base),
    .mask     (mask),
    .cur_max  (in_max),
    .cur_idx  (in_idx),
    .new_max  (upd_max),
    .new_idx  (upd_idx)
`ifdef LENET_RESULT_TOP2_EN
    ,
    .cur_max2 (run_max2),
    .cur_idx2 (run_idx2),
    .cur_has2 (in_has2),
    .new_max2 (upd_max2),
    .new_idx2 (upd_idx2),
    .new_has2 (upd_has2)
`endif
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state        <= IDLE;
      sram_raddr_f <= '0;
      rd_valid     <= 1'b0;
      rd_addr      <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_score <= '0;
      run_max      <= '0;
      run_idx      <= '0;
`ifdef LENET_RESULT_TOP2_EN
      run_max2      <= '0;
      run_idx2      <= '0;
      run_has2      <= 1'b0;
      result_class2 <= '0;
      result_score2 <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
      if (rd_valid) begin
        run_max <= upd_max;
        run_idx <= upd_idx;
`ifdef LENET_RESULT_TOP2_EN
        run_max2 <= upd_max2;
        run_idx2 <= upd_idx2;
        run_has2 <= upd_has2;
`endif
      end

      case (state)
        IDLE: begin
          if (fc2_done) begin
            state        <= READ;
            sram_raddr_f <= '0;
            busy         <= 1'b1;
          end
        end
        READ: begin
          rd_valid <= 1'b1;
          rd_addr  <= sram_raddr_f;
          if (sram_raddr_f == ADDR_WIDTH'(NWORD - 1)) begin
            state        <= LAST;
            sram_raddr_f <= '0;
          end else begin
            sram_raddr_f <= sram_raddr_f + 1'b1;
          end
        end
        LAST: begin
          // rd_valid is always set here: the final word is on the bus.
          state        <= HOLD;
          busy         <= 1'b0;
          result_valid <= 1'b1;
          result_class <= upd_idx;
          result_score <= upd_max;
`ifdef LENET_RESULT_TOP2_EN
          result_class2 <= upd_idx2;
          result_score2 <= upd_max2;
`endif
        end
        HOLD: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_result_reader.sv
// Self-checking bench for lenet_result_reader: table-driven score vectors
// plus hand-written sequences for HOLD stalls and mid-read reset.
module tb_lenet_result_reader;
  import lenet_pkg::*;

  logic                         clk = 1'b0;
  logic                         srstn;
  logic                         fc2_done;
  logic        [ADDR_WIDTH-1:0] sram_raddr_f;
  logic        [WORD_WIDTH-1:0] sram_rdata_f;
  logic                         busy;
  logic                         result_valid;
  logic                         result_ready;
  logic        [CLASS_W-1:0]    result_class;
  logic signed [DATA_WIDTH-1:0] result_score;
`ifdef LENET_RESULT_TOP2_EN
  logic        [CLASS_W-1:0]    result_class2;
  logic signed [DATA_WIDTH-1:0] result_score2;
`endif

  lenet_result_reader dut (
    .clk          (clk),
    .srstn        (srstn),
    .fc2_done     (fc2_done),
    .sram_raddr_f (sram_raddr_f),
    .sram_rdata_f (sram_rdata_f),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_score (result_score)
`ifdef LENET_RESULT_TOP2_EN
    ,
    .result_class2 (result_class2),
    .result_score2 (result_score2)
`endif
  );

  always #5 clk = ~clk;

  // SRAM_f model: registered read, data one cycle after the address.
  logic [WORD_WIDTH-1:0] mem [4];
  always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0][7:0] s;
    int cls;
    int score;
    int cls2;
    int score2;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9,
                              input int c, sc, c2, sc2);
    vec_t v;
    v.s[0] = 8'(a0); v.s[1] = 8'(a1); v.s[2] = 8'(a2); v.s[3] = 8'(a3);
    v.s[4] = 8'(a4); v.s[5] = 8'(a5); v.s[6] = 8'(a6); v.s[7] = 8'(a7);
    v.s[8] = 8'(a8); v.s[9] = 8'(a9);
    v.cls = c; v.score = sc; v.cls2 = c2; v.score2 = sc2;
    return v;
  endfunction

  // Unused lanes hold 99, larger than most winners, so masking is exercised.
  task automatic load(input vec_t v);
    for (int w = 0; w < 4; w++) mem[w] = 32'h63636363;
    for (int i = 0; i < CLASS_NUM; i++)
      mem[i / 4][31 - 8 * (i % 4) -: 8] = v.s[i];
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_valid"}, int'(result_valid), 1);
    check({tag, "_class"}, int'(result_class), v.cls);
    check({tag, "_score"}, int'(result_score), v.score);
`ifdef LENET_RESULT_TOP2_EN
    check({tag, "_class2"}, int'(result_class2), v.cls2);
    check({tag, "_score2"}, int'(result_score2), v.score2);
`endif
  endtask

  // Pulse fc2_done; fixed-latency check of address trace, busy and result.
  // Ends in the first cycle with result_valid expected high.
  task automatic start_and_trace(input string tag, input vec_t v);
    int exp_addr[4] = '{0, 1, 2, 0};
    load(v);
    @(negedge clk); fc2_done = 1'b1;
    @(negedge clk); fc2_done = 1'b0;   // cycle T+1
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s_addr_c%0d", tag, c + 1), int'(sram_raddr_f), exp_addr[c]);
      check($sformatf("%s_busy_c%0d", tag, c + 1), int'(busy), 1);
      check($sformatf("%s_nvalid_c%0d", tag, c + 1), int'(result_valid), 0);
      @(negedge clk);
    end
    check({tag, "_busy_done"}, int'(busy), 0);
    check({tag, "_addr_done"}, int'(sram_raddr_f), 0);
    check_result(tag, v);
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_valid_clr"}, int'(result_valid), 0);
  endtask

  initial begin
    fc2_done     = 1'b0;
    result_ready = 1'b0;
    srstn        = 1'b0;
    for (int w = 0; w < 4; w++) mem[w] = '0;

    vecs[0] = mk(3, -5, 7, 1, 0, 12, -128, 4, 9, 2,           5, 12, 8, 9);
    vecs[1] = mk(-128, -128, -128, -128, -128, -128, -128, -128, -128, -128,
                 0, -128, 1, -128);
    vecs[2] = mk(5, 5, 5, 127, 5, 5, 5, 127, 5, 5,             3, 127, 7, 127);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,                 9, 1, 0, 0);
    vecs[4] = mk(-1, -2, -3, -4, -5, -6, -7, -8, -9, -10,      0, -1, 1, -2);
    vecs[5] = mk(-128, -1, -128, -128, -128, -128, -128, -128, -128, -128,
                 1, -1, 0, -128);

    // Reset state
    #12;
    check("rst_valid", int'(result_valid), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_addr",  int'(sram_raddr_f), 0);
    check("rst_class", int'(result_class), 0);
    check("rst_score", int'(result_score), 0);
    @(negedge clk); srstn = 1'b1;
    @(negedge clk);

    // Table-driven vectors, ready held ready at the result
    for (int i = 0; i < 6; i++) begin
      start_and_trace($sformatf("v%0d", i), vecs[i]);
      handshake($sformatf("v%0d", i));
      @(negedge clk);
    end

    // HOLD stall for 10 cycles with a stray fc2_done; one handshake only
    start_and_trace("hold", vecs[0]);
    for (int c = 0; c < 10; c++) begin
      fc2_done = (c == 3);
      @(negedge clk);
      check_result($sformatf("hold_c%0d", c), vecs[0]);
      check($sformatf("hold_busy_c%0d", c), int'(busy), 0);
    end
    fc2_done = 1'b0;
    handshake("hold");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("after_valid_c%0d", c), int'(result_valid), 0);
      check($sformatf("after_busy_c%0d", c), int'(busy), 0);
    end

    // Reset mid-read at T+3, then a fresh transaction
    load(vecs[2]);
    @(negedge clk); fc2_done = 1'b1;
    @(negedge clk); fc2_done = 1'b0;   // T+1
    @(negedge clk);                    // T+2
    @(negedge clk);                    // T+3
    srstn = 1'b0;
    #1;
    check("mrst_valid", int'(result_valid), 0);
    check("mrst_busy",  int'(busy), 0);
    check("mrst_addr",  int'(sram_raddr_f), 0);
    check("mrst_class", int'(result_class), 0);
    check("mrst_score", int'(result_score), 0);
    @(negedge clk); srstn = 1'b1;
    @(negedge clk);
    check("mrst_idle_valid", int'(result_valid), 0);
    start_and_trace("fresh", vecs[2]);
    handshake("fresh");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
